// File: rtl/data_path_pkg.sv
// data_path_pkg: ALU opcodes, bus selects and memory FSM states shared by the datapath
package data_path_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RD   = 2'b01,
        S_WR   = 2'b10
    } mem_state_t;

    localparam logic [1:0] B1_PC   = 2'b00;
    localparam logic [1:0] B1_REG  = 2'b01;
    localparam logic [1:0] B1_MDR  = 2'b10;
    localparam logic [1:0] B2_ALU  = 2'b00;
    localparam logic [1:0] B2_BUS1 = 2'b01;
    localparam logic [1:0] B2_MEM  = 2'b10;

endpackage

// File: rtl/alu_gen.sv
// alu_gen: combinational ALU producing a WIDTH-bit result and NZVC flags
module alu_gen
    import data_path_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_t          op,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzvc
);

    logic c;
    logic v;

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (op)
            ALU_ADD: begin
                {c, result} = {1'b0, a} + {1'b0, b};
                v = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                // the extended top bit of the subtraction is the unsigned borrow
                {c, result} = {1'b0, a} - {1'b0, b};
                v = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: {c, result} = {a, 1'b0};
            ALU_SHR: {result, c} = {1'b0, a};
            default: result = '0;
        endcase
    end

    assign nzvc = {result[WIDTH-1], result == '0, v, c};

endmodule

// File: rtl/data_path_gen.sv
// data_path_gen: two-bus datapath with register file, PC, ALU, CCR and a request/ack memory FSM
module data_path_gen
    import data_path_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 4,
    localparam int RSEL_W = $clog2(NREG)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  from_memory,
    input  logic              mem_ack,
    output logic [WIDTH-1:0]  address,
    output logic [WIDTH-1:0]  to_memory,
    output logic              mem_req,
    output logic              mem_we,
    output logic              busy,
    output logic [WIDTH-1:0]  IR_out,
    output logic [3:0]        CCR_Result,
    input  logic [2:0]        ALU_Sel,
    input  logic [1:0]        Bus1_Sel,
    input  logic [1:0]        Bus2_Sel,
    input  logic [RSEL_W-1:0] Src_Sel,
    input  logic [RSEL_W-1:0] Dst_Sel,
    input  logic [RSEL_W-1:0] Opa_Sel,
    input  logic [RSEL_W-1:0] Opb_Sel,
    input  logic              IR_Load,
    input  logic              MAR_Load,
    input  logic              PC_Load,
    input  logic              PC_Inc,
    input  logic              Reg_Load,
    input  logic              CCR_Load,
    input  logic              Mem_Rd,
    input  logic              Mem_Wr
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] wdr;
    logic [WIDTH-1:0] regs [NREG];
    logic [3:0]       ccr;
    logic [WIDTH-1:0] bus1;
    logic [WIDTH-1:0] bus2;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_nzvc;
    logic             idle;
    mem_state_t       state;
    mem_state_t       state_nx;

    alu_gen #(.WIDTH(WIDTH)) u_alu (
        .a      (regs[Opa_Sel]),
        .b      (regs[Opb_Sel]),
        .op     (alu_op_t'(ALU_Sel)),
        .result (alu_result),
        .nzvc   (alu_nzvc)
    );

    always_comb begin
        bus1 = Bus1_Sel == B1_PC  ? pc :
               Bus1_Sel == B1_REG ? regs[Src_Sel] :
               Bus1_Sel == B1_MDR ? mdr : '0;
        bus2 = Bus2_Sel == B2_ALU  ? alu_result :
               Bus2_Sel == B2_BUS1 ? bus1 :
               Bus2_Sel == B2_MEM  ? from_memory : '0;
    end

    assign idle = state == S_IDLE;

    // a simultaneous read and write request performs only the write
    always_comb begin
        state_nx = state;
        if (idle)
            state_nx = Mem_Wr ? S_WR : Mem_Rd ? S_RD : S_IDLE;
        else
            state_nx = mem_ack ? S_IDLE : state;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
            pc    <= '0;
            mar   <= '0;
            ir    <= '0;
            mdr   <= '0;
            wdr   <= '0;
            ccr   <= '0;
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            state <= state_nx;
            if (IR_Load)
                ir <= bus2;
            if (MAR_Load && idle)
                mar <= bus2;
            if (PC_Load)
                pc <= bus2;
            else if (PC_Inc)
                pc <= pc + WIDTH'(1);
            if (Reg_Load)
                regs[Dst_Sel] <= bus2;
            if (CCR_Load)
                ccr <= alu_nzvc;
            if (idle && Mem_Wr)
                wdr <= bus1;
            if (state == S_RD && mem_ack)
                mdr <= from_memory;
        end
    end

    assign address    = mar;
    assign to_memory  = wdr;
    assign busy       = !idle;
    assign mem_req    = !idle;
    assign mem_we     = state == S_WR;
    assign IR_out     = ir;
    assign CCR_Result = ccr;

endmodule

// File: doc/data_path_gen.md
DATA_PATH_GEN -- requirements
Module: data_path_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath/address width (4..32).
REQ-002 SHALL have parameter NREG, default 4, general-register count (power of 2, 2..16); RSEL_W = clog2(NREG) derived locally.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  asynchronous, active-low reset.
REQ-005 from_memory  in  WIDTH  memory read data; mem_ack  in  1  memory completes current request.
REQ-006 address  out  WIDTH  memory address (=MAR); to_memory  out  WIDTH  write data (=WDR).
REQ-007 mem_req  out  1  request pending; mem_we  out  1  1=write, 0=read; busy  out  1  memory FSM not IDLE.
REQ-008 IR_out  out  WIDTH  instruction register; CCR_Result  out  4  stored NZVC.
REQ-009 ALU_Sel  in  3; Bus1_Sel, Bus2_Sel  in  2 each; Src_Sel, Dst_Sel, Opa_Sel, Opb_Sel  in  RSEL_W each.
REQ-010 IR_Load, MAR_Load, PC_Load, PC_Inc, Reg_Load, CCR_Load, Mem_Rd, Mem_Wr  in  1 each, active-high strobes.

Function
REQ-011 Bus1 SHALL be: 00 PC, 01 R[Src_Sel], 10 MDR, 11 zero.
REQ-012 Bus2 SHALL be: 00 ALU_Result, 01 Bus1, 10 from_memory, 11 zero.
REQ-013 IR, MAR load from Bus2; R[Dst_Sel] loads from Bus2 on Reg_Load; one register write per cycle.
REQ-014 PC_Load (from Bus2) SHALL take priority over PC_Inc; PC_Inc wraps 2^WIDTH-1 -> 0.
REQ-015 ALU operands R[Opa_Sel], R[Opb_Sel]; ops: 000 add, 001 sub(a-b), 010 and, 011 or, 100 xor, 101 not a, 110 shl a, 111 shr a (logical), all modulo 2^WIDTH.
REQ-016 N = result MSB; Z = result==0; V = signed overflow for add/sub, else 0; C = carry out (add), borrow (sub, a<b unsigned), bit shifted out (shl/shr), else 0.
REQ-017 CCR_Result SHALL load NZVC on CCR_Load.
REQ-018 Memory FSM states IDLE, RD, WR; busy=1 in RD/WR; mem_req=1 in RD/WR; mem_we=1 only in WR.
REQ-019 IDLE+Mem_Wr -> WR, WDR<=Bus1 same edge; IDLE+Mem_Rd (no Mem_Wr) -> RD; Mem_Rd and Mem_Wr together SHALL perform the write only.
REQ-020 RD+mem_ack -> IDLE with MDR<=from_memory; WR+mem_ack -> IDLE; no ack -> hold state indefinitely (unbounded wait states).
REQ-021 Mem_Rd/Mem_Wr while busy SHALL be ignored; MAR_Load while busy SHALL be ignored (address stable through transaction).
REQ-022 mem_ack in IDLE SHALL be ignored; back-to-back transactions allowed, new request accepted the cycle after return to IDLE.
REQ-023 Non-memory loads (IR, PC, registers, CCR) SHALL operate regardless of busy.

Reset
REQ-024 Reset low SHALL immediately clear PC, MAR, IR_out, MDR, WDR, all R[i], CCR_Result to 0 and FSM to IDLE (mem_req=0, mem_we=0, busy=0).
REQ-025 Reset mid-transaction SHALL abandon it; no MDR update from a late mem_ack.
REQ-026 Release of Reset SHALL take effect on the first Clk edge with Reset high.

Structure
REQ-027 ALU opcode constants and FSM state encodings SHALL live in shared package data_path_pkg.
REQ-028 ALU SHALL be sub-module alu_gen (parameter WIDTH, combinational, outputs result and NZVC); register file, PC, FSM inline.

Verification
REQ-029 WIDTH=8: R0=0x7F, R1=0x01, ALU_Sel=add, CCR_Load -> result 0x80, CCR_Result=1010.
REQ-030 R0=0x00, R1=0x01, sub -> result 0xFF, CCR_Result=1001; shl of 0x80 -> 0x00, NZVC=0101.
REQ-031 MAR=0x10, Mem_Rd, mem_ack after 3 cycles with from_memory=0xA5 -> busy high 3 cycles, MDR=0xA5, address=0x10 throughout even with MAR_Load pulsed.
REQ-032 Mem_Rd+Mem_Wr same cycle, Bus1=0x3C -> mem_we=1, to_memory=0x3C, Mem_Rd during WR ignored.
REQ-033 PC=0xFF, PC_Inc -> 0x00; PC_Load+PC_Inc with Bus2=0x40 -> PC=0x40.
REQ-034 Reset asserted in RD, then mem_ack -> MDR=0, busy=0, mem_req=0 immediately.
